// File: rtl/viterbi_frame_sequencer.sv
`timescale 1ns/1ps
// viterbi_frame_sequencer
// Frames a serial bit stream into a rate-1/2, K=9 convolutional encoder.
// Each frame feeds frame_len data bits and then TAIL_LEN zero bits, so the
// encoder trellis always ends in state 0. Symbol tags (valid/sof/eof) are
// delayed by ENC_LAT cycles so that they line up with the encoder's
// registered Y output. The encoder cannot stall, so this block owns the timing.
//
// Ports
//   Clock      in   single clock, all state on posedge
//   Reset      in   asynchronous, active-low; clears all state
//   start      in   frame request, sampled only in IDLE
//   frame_len  in   data bits in frame, sampled with start (0 = ignored)
//   din        in   data bit
//   din_valid  in   din valid
//   din_ready  out  din consumed this cycle when din_valid & din_ready
//   enc_x      out  drives encoder X
//   y_valid    out  encoder Y carries a frame symbol this cycle
//   y_sof      out  first symbol of frame
//   y_eof      out  last tail symbol of frame
//   done       out  1-cycle pulse, same cycle as y_eof
//   frame_err  out  1-cycle pulse: input underrun aborted the data phase
//   busy       out  state != IDLE
//   frame_cnt  out  (VITERBI_SEQ_STATS_EN only) completed frames, wraps
//   err_cnt    out  (VITERBI_SEQ_STATS_EN only) underruns, saturates at 255
//
// Optional feature: define VITERBI_SEQ_STATS_EN to add frame_cnt / err_cnt.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start with a non-zero frame_len; enc_x held 0
// DATA  | one data bit per cycle into the encoder; underrun aborts
// TAIL  | TAIL_LEN zero bits to flush the encoder back to state 0

module viterbi_frame_sequencer #(
  parameter int LEN_W    = 12,
  parameter int TAIL_LEN = 8,
  parameter int ENC_LAT  = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             enc_x,
  output logic             y_valid,
  output logic             y_sof,
  output logic             y_eof,
  output logic             done,
  output logic             frame_err,
  output logic             busy
`ifdef VITERBI_SEQ_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } stateT;

  localparam logic [LEN_W-1:0] LenOne   = LEN_W'(1);
  localparam logic [LEN_W-1:0] TailInit = LEN_W'(TAIL_LEN);

  stateT            state, nextState;
  logic [LEN_W-1:0] cnt, cntNext;
  logic [LEN_W-1:0] tcnt, tcntNext;
  logic             firstData, firstDataNext;
  logic             tagValid, tagSof, tagEof;

  // Tag delay line; index ENC_LAT-1 is the stage aligned with encoder Y.
  logic [ENC_LAT-1:0] vDly, sofDly, eofDly;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tcnt      <= '0;
      firstData <= 1'b0;
    end else begin
      state     <= nextState;
      cnt       <= cntNext;
      tcnt      <= tcntNext;
      firstData <= firstDataNext;
    end
  end

  always_comb begin
    nextState     = state;
    cntNext       = cnt;
    tcntNext      = tcnt;
    firstDataNext = firstData;
    din_ready     = 1'b0;
    enc_x         = 1'b0;
    frame_err     = 1'b0;
    tagValid      = 1'b0;
    tagSof        = 1'b0;
    tagEof        = 1'b0;
    case (state)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          cntNext       = frame_len;
          firstDataNext = 1'b1;
          nextState     = DATA;
        end
      end
      DATA: begin
        din_ready     = 1'b1;
        tagValid      = 1'b1;
        tagSof        = firstData;
        firstDataNext = 1'b0;
        if (din_valid) begin
          enc_x   = din;
          cntNext = cnt - LenOne;
          if (cnt == LenOne) begin
            tcntNext  = TailInit;
            nextState = TAIL;
          end
        end else begin
          // Underrun: the encoder still clocks a (zero) symbol this cycle,
          // so it stays tagged valid and the frame is flushed normally.
          frame_err = 1'b1;
          cntNext   = '0;
          tcntNext  = TailInit;
          nextState = TAIL;
        end
      end
      TAIL: begin
        tagValid = 1'b1;
        tcntNext = tcnt - LenOne;
        if (tcnt == LenOne) begin
          tagEof    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      vDly   <= '0;
      sofDly <= '0;
      eofDly <= '0;
    end else begin
      vDly[0]   <= tagValid;
      sofDly[0] <= tagSof;
      eofDly[0] <= tagEof;
      for (int i = 1; i < ENC_LAT; i++) begin
        vDly[i]   <= vDly[i-1];
        sofDly[i] <= sofDly[i-1];
        eofDly[i] <= eofDly[i-1];
      end
    end
  end

  assign y_valid = vDly[ENC_LAT-1];
  assign y_sof   = sofDly[ENC_LAT-1];
  assign y_eof   = eofDly[ENC_LAT-1];
  assign done    = eofDly[ENC_LAT-1];
  assign busy    = (state != IDLE);

`ifdef VITERBI_SEQ_STATS_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (frame_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
